// File: rtl/mux_n_pipe.sv
// N-way select of a multi-channel input, registered behind a two-entry
// (output + skid) valid/ready pipeline stage with an out-of-range error counter.
module mux_n_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             err_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;
  logic             r_skid_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_beat_data;
  logic             w_beat_err;
  logic             w_accept;
  logic             w_out_free;
  logic [WIDTH-1:0] w_out_data_nxt;
  logic             w_out_err_nxt;
  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_skid_data_nxt;
  logic             w_skid_err_nxt;
  logic             w_skid_valid_nxt;
  logic [CNT_W-1:0] w_err_cnt_nxt;

  // Channel select; an index with no matching channel yields zero data and err.
  always_comb begin
    w_beat_data = '0;
    w_beat_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_beat_data = in_data[k*WIDTH +: WIDTH];
        w_beat_err  = 1'b0;
      end
    end
  end

  assign w_accept   = in_valid && r_in_ready;
  assign w_out_free = !r_out_valid || out_ready;

  // Pipeline next state: OUT refills from SKID first so beat order is kept.
  always_comb begin
    w_out_data_nxt   = r_out_data;
    w_out_err_nxt    = r_out_err;
    w_out_valid_nxt  = r_out_valid;
    w_skid_data_nxt  = r_skid_data;
    w_skid_err_nxt   = r_skid_err;
    w_skid_valid_nxt = r_skid_valid;
    if (w_out_free) begin
      if (r_skid_valid) begin
        w_out_data_nxt   = r_skid_data;
        w_out_err_nxt    = r_skid_err;
        w_out_valid_nxt  = 1'b1;
        w_skid_valid_nxt = w_accept;
        if (w_accept) begin
          w_skid_data_nxt = w_beat_data;
          w_skid_err_nxt  = w_beat_err;
        end
      end else begin
        w_out_valid_nxt = w_accept;
        if (w_accept) begin
          w_out_data_nxt = w_beat_data;
          w_out_err_nxt  = w_beat_err;
        end
      end
    end else if (w_accept) begin
      w_skid_data_nxt  = w_beat_data;
      w_skid_err_nxt   = w_beat_err;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Saturating count of accepted out-of-range beats.
  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (w_accept && w_beat_err && (r_err_cnt != CNT_MAX)) begin
      w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data   <= '0;
      r_out_err    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_out_data   <= w_out_data_nxt;
      r_out_err    <= w_out_err_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_err   <= w_skid_err_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign out_valid = r_out_valid;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: a 4-channel instance checked every cycle against a
// queue model, and a 3-channel instance for out-of-range and saturation cases.
module tb_mux_n_pipe;

  localparam int unsigned WA = 64;
  localparam int unsigned NA = 4;
  localparam int unsigned SA = 2;
  localparam int unsigned WC = 8;
  localparam int unsigned NC = 3;
  localparam int unsigned SC = 2;
  localparam int unsigned RAND_CYCLES = 10000;
  localparam int unsigned SAT_FILL    = 65533;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             a_reset    = 1'b0;
  logic [NA*WA-1:0] a_in_data  = '0;
  logic [SA-1:0]    a_sel      = '0;
  logic             a_in_valid = 1'b0;
  logic             a_in_ready;
  logic [WA-1:0]    a_out_data;
  logic             a_out_err;
  logic             a_out_valid;
  logic             a_out_ready = 1'b0;
  logic [15:0]      a_err_cnt;

  logic             c_reset    = 1'b0;
  logic [NC*WC-1:0] c_in_data  = '0;
  logic [SC-1:0]    c_sel      = '0;
  logic             c_in_valid = 1'b0;
  logic             c_in_ready;
  logic [WC-1:0]    c_out_data;
  logic             c_out_err;
  logic             c_out_valid;
  logic             c_out_ready = 1'b0;
  logic [15:0]      c_err_cnt;

  mux_n_pipe #(.WIDTH(WA), .NUM_IN(NA), .SEL_W(SA)) dut_a (
    .clk(clk), .reset(a_reset), .in_data(a_in_data), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_err(a_out_err), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .err_cnt(a_err_cnt)
  );

  mux_n_pipe #(.WIDTH(WC), .NUM_IN(NC), .SEL_W(SC)) dut_c (
    .clk(clk), .reset(c_reset), .in_data(c_in_data), .sel(c_sel),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_err(c_out_err), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .err_cnt(c_err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: the block is a FIFO of depth two whose head is out_*.
  logic [WA:0]  m_q[$];
  logic [WA:0]  m_b;
  bit           m_armed = 1'b0;
  bit           m_acc;
  bit           m_cons;
  int unsigned  m_errs = 0;
  int unsigned  m_rst_cnt = 0;

  function automatic logic [WA:0] beat_a(input logic [SA-1:0] s, input logic [NA*WA-1:0] d);
    int unsigned idx;
    idx = s;
    if (idx < NA) return {1'b0, d[idx*WA +: WA]};
    return {1'b1, {WA{1'b0}}};
  endfunction

  always @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      m_q.delete();
      m_armed = 1'b0;
      m_errs  = 0;
      m_rst_cnt++;
    end else begin
      m_acc  = a_in_valid && m_armed && (m_q.size() < 2);
      m_cons = (m_q.size() > 0) && a_out_ready;
      if (m_cons) void'(m_q.pop_front());
      if (m_acc) begin
        m_b = beat_a(a_sel, a_in_data);
        m_q.push_back(m_b);
        if (m_b[WA] && (m_errs < 65535)) m_errs++;
      end
      m_armed = 1'b1;
    end
  end

  logic          p_stall = 1'b0;
  logic [WA-1:0] p_data  = '0;
  logic          p_err   = 1'b0;
  int unsigned   p_rst_cnt = 0;

  always @(negedge clk) begin
    chk("a_in_ready", 64'(a_in_ready), 64'(m_armed && (m_q.size() < 2)));
    chk("a_out_valid", 64'(a_out_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("a_out_data", a_out_data, m_q[0][WA-1:0]);
      chk("a_out_err", 64'(a_out_err), 64'(m_q[0][WA]));
    end
    chk("a_err_cnt", 64'(a_err_cnt), 64'(m_errs));
    if (a_reset) chk("a_out_data_in_reset", a_out_data, 64'h0);
    if (p_stall && (p_rst_cnt == m_rst_cnt)) begin
      chk("a_stall_valid", 64'(a_out_valid), 64'h1);
      chk("a_stall_data", a_out_data, p_data);
      chk("a_stall_err", 64'(a_out_err), 64'(p_err));
    end
    p_stall   = a_out_valid && !a_out_ready;
    p_data    = a_out_data;
    p_err     = a_out_err;
    p_rst_cnt = m_rst_cnt;
  end

  // Channel k carries {base, k}, so the selected value is recognisable.
  task automatic set_a(input logic [SA-1:0] s, input logic [31:0] base);
    for (int k = 0; k < int'(NA); k++) a_in_data[k*WA +: WA] = {base, 32'(k)};
    a_sel = s;
  endtask

  task automatic run_a();
    #1 a_reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("a_rst_in_ready", 64'(a_in_ready), 64'h0);
    chk("a_rst_out_valid", 64'(a_out_valid), 64'h0);
    chk("a_rst_err_cnt", 64'(a_err_cnt), 64'h0);
    @(posedge clk); #1 a_reset = 1'b0;
    @(negedge clk);
    chk("a_ready_before_first_edge", 64'(a_in_ready), 64'h0);
    @(posedge clk); #1;
    set_a(2'd2, 32'hDEAD_BEEF);
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("a_ready_after_first_edge", 64'(a_in_ready), 64'h1);
    chk("a_empty_after_reset", 64'(a_out_valid), 64'h0);
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    chk("a_sel2_valid", 64'(a_out_valid), 64'h1);
    chk("a_sel2_data", a_out_data, 64'hDEAD_BEEF_0000_0002);
    chk("a_sel2_err", 64'(a_out_err), 64'h0);

    // Three beats against a stalled output.
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    set_a(2'd0, 32'h1111_1111);
    a_in_valid = 1'b1;
    @(posedge clk); #1 set_a(2'd1, 32'h2222_2222);
    @(negedge clk);
    chk("a_b1_head", a_out_data, 64'h1111_1111_0000_0000);
    chk("a_b1_ready", 64'(a_in_ready), 64'h1);
    @(posedge clk); #1 set_a(2'd3, 32'h3333_3333);
    @(negedge clk);
    chk("a_full_ready", 64'(a_in_ready), 64'h0);
    chk("a_full_head", a_out_data, 64'h1111_1111_0000_0000);
    @(posedge clk);
    @(negedge clk);
    chk("a_third_blocked", 64'(a_in_ready), 64'h0);
    chk("a_hold_head", a_out_data, 64'h1111_1111_0000_0000);
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("a_drain_b2", a_out_data, 64'h2222_2222_0000_0001);
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    chk("a_drain_b3", a_out_data, 64'h3333_3333_0000_0003);
    chk("a_drain_b3_valid", 64'(a_out_valid), 64'h1);
    @(posedge clk);
    @(negedge clk);
    chk("a_drained", 64'(a_out_valid), 64'h0);

    // Reset with both entries full; nothing old may come out afterwards.
    a_out_ready = 1'b0;
    set_a(2'd1, 32'h4444_4444);
    a_in_valid = 1'b1;
    @(posedge clk); #1 set_a(2'd2, 32'h5555_5555);
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    chk("a_prefull_valid", 64'(a_out_valid), 64'h1);
    chk("a_prefull_ready", 64'(a_in_ready), 64'h0);
    #1 a_reset = 1'b1;
    #1;
    chk("a_async_valid", 64'(a_out_valid), 64'h0);
    chk("a_async_ready", 64'(a_in_ready), 64'h0);
    chk("a_async_err_cnt", 64'(a_err_cnt), 64'h0);
    chk("a_async_data", a_out_data, 64'h0);
    repeat (2) @(posedge clk);
    #1 a_reset = 1'b0;
    a_out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("a_no_stale_beat", 64'(a_out_valid), 64'h0);
    end

    for (int i = 0; i < int'(RAND_CYCLES); i++) begin
      @(posedge clk); #1;
      a_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 1));
      a_sel       = SA'($urandom);
      for (int k = 0; k < int'(NA * WA / 32); k++) a_in_data[k*32 +: 32] = $urandom;
    end
    @(posedge clk); #1;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic run_c();
    #1 c_reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("c_rst_out_valid", 64'(c_out_valid), 64'h0);
    chk("c_rst_err_cnt", 64'(c_err_cnt), 64'h0);
    @(posedge clk); #1 c_reset = 1'b0;
    c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_in_data  = 24'hC2_C1_C0;
    c_sel      = 2'd1;
    c_in_valid = 1'b1;
    @(posedge clk); #1 c_in_valid = 1'b0;
    @(negedge clk);
    chk("c_sel1_valid", 64'(c_out_valid), 64'h1);
    chk("c_sel1_data", 64'(c_out_data), 64'hC1);
    chk("c_sel1_err", 64'(c_out_err), 64'h0);
    chk("c_sel1_err_cnt", 64'(c_err_cnt), 64'h0);
    @(posedge clk); #1 c_sel = 2'd3; c_in_valid = 1'b1;
    @(posedge clk); #1 c_in_valid = 1'b0;
    @(negedge clk);
    chk("c_sel3_valid", 64'(c_out_valid), 64'h1);
    chk("c_sel3_data", 64'(c_out_data), 64'h0);
    chk("c_sel3_err", 64'(c_out_err), 64'h1);
    chk("c_sel3_err_cnt", 64'(c_err_cnt), 64'h1);
    @(posedge clk); #1 c_sel = 2'd2; c_in_valid = 1'b1;
    @(posedge clk); #1 c_in_valid = 1'b0;
    @(negedge clk);
    chk("c_sel2_data", 64'(c_out_data), 64'hC2);
    chk("c_sel2_err", 64'(c_out_err), 64'h0);
    chk("c_sel2_err_cnt", 64'(c_err_cnt), 64'h1);

    // Stream out-of-range beats up to one below saturation, then past it.
    @(posedge clk); #1 c_sel = 2'd3; c_in_valid = 1'b1;
    repeat (SAT_FILL) @(posedge clk);
    #1 c_in_valid = 1'b0;
    @(negedge clk);
    chk("c_err_cnt_fffe", 64'(c_err_cnt), 64'hFFFE);
    @(posedge clk); #1 c_in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 c_in_valid = 1'b0;
    @(negedge clk);
    chk("c_err_cnt_sat", 64'(c_err_cnt), 64'hFFFF);
    @(posedge clk); #1 c_in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 c_in_valid = 1'b0;
    @(negedge clk);
    chk("c_err_cnt_held", 64'(c_err_cnt), 64'hFFFF);
    chk("c_sat_out_err", 64'(c_out_err), 64'h1);
  endtask

  initial begin
    fork
      run_a();
      run_c();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
